// File: rtl/split_pkg.sv
// Shared layer parameters for the inception split stage.
// Defaults for word shape/fan-out, data width, pend-mask helper.
package split_pkg;

  localparam int SPLIT_NIN = 3;
  localparam int SPLIT_NUM = 3;
  localparam int SPLIT_BW  = 8;
  localparam int SPLIT_DW  = SPLIT_NIN * SPLIT_BW;

  // Low n bits set; callers slice to their fan-out width.
  function automatic logic [31:0] pend_mask(input int n);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 32; i++)
      if (i < n) m[i] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/split_entry.sv
// One broadcast word plus its per-branch pending mask.
// Ports: load/load_data in, fire in; full, drain, valid, data out.
module split_entry
  import split_pkg::*;
#(
  parameter int DW = SPLIT_DW,
  parameter int NS = SPLIT_NUM
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [DW-1:0] load_data,
  input  logic [NS-1:0] fire,
  output logic          full,
  output logic          drain,
  output logic [NS-1:0] valid,
  output logic [DW-1:0] data
);

  localparam logic [31:0] ALL = pend_mask(NS);

  logic          full_q;
  logic [NS-1:0] pend_q;
  logic [DW-1:0] data_q;

  assign full  = full_q;
  assign data  = data_q;
  assign valid = {NS{full_q}} & pend_q;
  // Last outstanding branches take the word this cycle.
  assign drain = full_q & ((pend_q & ~fire) == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      pend_q <= '0;
      data_q <= '0;
    end else if (load) begin
      full_q <= 1'b1;
      pend_q <= ALL[NS-1:0];
      data_q <= load_data;
    end else if (drain) begin
      full_q <= 1'b0;
      pend_q <= '0;
    end else begin
      pend_q <= pend_q & ~fire;
    end
  end

endmodule

// File: rtl/split.sv
// Eager fork: broadcasts one upstream word to NUM_SPLIT branches.
// Macro SPLIT_SKID_BUF_EN adds a second (skid) entry; registered ready.
module split
  import split_pkg::*;
#(
  parameter int Nin       = SPLIT_NIN,
  parameter int NUM_SPLIT = SPLIT_NUM,
  parameter int BIT_WIDTH = SPLIT_BW
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     prev_layer_valid,
  output logic                     prev_layer_rdy,
  input  logic [Nin*BIT_WIDTH-1:0] prev_layer_data,
  input  logic [NUM_SPLIT-1:0]     next_layer_rdy,
  output logic [NUM_SPLIT-1:0]     next_layer_valid,
  output logic [Nin*BIT_WIDTH-1:0] next_layer_data
);

  localparam int DW = Nin * BIT_WIDTH;
  localparam int NS = NUM_SPLIT;

  logic [NS-1:0] fire;
  logic          acc;

  assign fire = next_layer_valid & next_layer_rdy;
  assign acc  = prev_layer_valid & prev_layer_rdy;

`ifdef SPLIT_SKID_BUF_EN

  logic          rp_q;
  logic          wp_q;
  logic [1:0]    full;
  logic [1:0]    drain;
  logic [1:0]    load;
  logic [NS-1:0] vld    [2];
  logic [NS-1:0] fire_e [2];
  logic [DW-1:0] dat    [2];

  // Only register state feeds ready.
  assign prev_layer_rdy = ~(full[0] & full[1]);

  assign load[0]   = acc & ~wp_q;
  assign load[1]   = acc &  wp_q;
  // Only the head entry sees branch handshakes.
  assign fire_e[0] = rp_q ? '0 : fire;
  assign fire_e[1] = rp_q ? fire : '0;

  assign next_layer_valid = rp_q ? vld[1] : vld[0];
  assign next_layer_data  = rp_q ? dat[1] : dat[0];

  for (genvar e = 0; e < 2; e++) begin : g_ent
    split_entry #(.DW(DW), .NS(NS)) u_ent (
      .clk       (clk),
      .rst       (rst),
      .load      (load[e]),
      .load_data (prev_layer_data),
      .fire      (fire_e[e]),
      .full      (full[e]),
      .drain     (drain[e]),
      .valid     (vld[e]),
      .data      (dat[e])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rp_q <= 1'b0;
      wp_q <= 1'b0;
    end else begin
      if (acc) wp_q <= ~wp_q;
      if (rp_q ? drain[1] : drain[0]) rp_q <= ~rp_q;
    end
  end

`else

  logic full;
  logic drain;

  assign prev_layer_rdy = ~full | drain;

  split_entry #(.DW(DW), .NS(NS)) u_ent (
    .clk       (clk),
    .rst       (rst),
    .load      (acc),
    .load_data (prev_layer_data),
    .fire      (fire),
    .full      (full),
    .drain     (drain),
    .valid     (next_layer_valid),
    .data      (next_layer_data)
  );

`endif

endmodule
